// File: rtl/mem_host_port_pkg.sv
// Shared widths, FSM state encoding and memory control encodings for the
// host load/dump port of the 128x52 register-file memory.
package mem_host_port_pkg;

  localparam int DW = 52;
  localparam int AW = 7;
  localparam logic [AW-1:0] LAST_ADDR = 7'd127;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  // {NCE, NWRT}, both active-low
  localparam logic [1:0] MEM_IDLE = 2'b11;
  localparam logic [1:0] MEM_RD   = 2'b01;
  localparam logic [1:0] MEM_WR   = 2'b00;

endpackage

// File: rtl/mem_addr_counter.sv
// Word address counter for the host port: clear has priority over increment,
// and o_last flags the final word so the FSM can end the transfer.
module mem_addr_counter
  import mem_host_port_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [AW-1:0] o_addr,
  output logic          o_last
);

  logic [AW-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_addr <= '0;
    end else if (i_clr) begin
      r_addr <= '0;
    end else if (i_inc) begin
      r_addr <= r_addr + AW'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_addr == LAST_ADDR);

endmodule

// File: rtl/mem_host_port.sv
// Host-side load/dump port: streams a 128-word image into the memory (1 word/cycle)
// and streams it back out (3 cycles/word: request, capture, present).
module mem_host_port
  import mem_host_port_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start_load,
  input  logic          start_dump,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic [4:0]    RA,
  output logic [1:0]    CA,
  output logic          NWRT,
  output logic          NCE,
  output logic [DW-1:0] DIN,
  input  logic [DW-1:0] DO
);

  state_t        r_state;
  logic          r_done;
  logic [DW-1:0] r_out_data;

  logic [AW-1:0] w_addr;
  logic          w_last;
  logic          w_load_acc;
  logic          w_out_acc;
  logic          w_term;
  logic          w_clr;
  logic          w_inc;
  logic [1:0]    w_mem_ctl;

  assign w_load_acc = (r_state == ST_LOAD) && in_valid;
  assign w_out_acc  = (r_state == ST_OUT) && out_ready;
  assign w_term     = (w_load_acc || w_out_acc) && w_last;
  assign w_inc      = (w_load_acc || w_out_acc) && !w_last;
  assign w_clr      = ((r_state == ST_IDLE) && (start_load || start_dump)) || w_term;

  mem_addr_counter u_addr (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (w_clr),
    .i_inc  (w_inc),
    .o_addr (w_addr),
    .o_last (w_last)
  );

  // Gated by rstn so a word in flight when reset hits is never written.
  always_comb begin
    w_mem_ctl = MEM_IDLE;
    if (rstn) begin
      case (r_state)
        ST_LOAD:   w_mem_ctl = in_valid ? MEM_WR : MEM_IDLE;
        ST_RD_REQ: w_mem_ctl = MEM_RD;
        default:   w_mem_ctl = MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_done     <= 1'b0;
      r_out_data <= '0;
    end else begin
      r_done <= w_term;
      case (r_state)
        ST_IDLE: begin
          if (start_load) begin
            r_state <= ST_LOAD;
          end else if (start_dump) begin
            r_state <= ST_RD_REQ;
          end
        end
        ST_LOAD: begin
          if (w_term) r_state <= ST_IDLE;
        end
        ST_RD_REQ: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          r_out_data <= DO;
          r_state    <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) r_state <= w_last ? ST_IDLE : ST_RD_REQ;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign {NCE, NWRT} = w_mem_ctl;
  assign RA          = w_addr[AW-1:2];
  assign CA          = w_addr[1:0];
  assign DIN         = (r_state == ST_LOAD) ? in_data : '0;
  assign in_ready    = (r_state == ST_LOAD);
  assign out_valid   = (r_state == ST_OUT);
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign out_data    = r_out_data;

endmodule

// File: tb/tb_mem_host_port.sv
// Bench for mem_host_port: behavioural 128x52 memory on the RA/CA/NCE/NWRT pins,
// a decode vector table, then directed and randomized load/dump transfers.
module tb_mem_host_port;
  import mem_host_port_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_load = 1'b0;
  logic          start_dump = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [4:0]    RA;
  logic [1:0]    CA;
  logic          NWRT;
  logic          NCE;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DO = '0;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [128];
  logic [DW-1:0] img [128];
  int            wr_addr_q[$];

  mem_host_port dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_load (start_load),
    .start_dump (start_dump),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .RA         (RA),
    .CA         (CA),
    .NWRT       (NWRT),
    .NCE        (NCE),
    .DIN        (DIN),
    .DO         (DO)
  );

  always #5 clk = ~clk;

  // Memory model: write on NCE=NWRT=0, read data appears after the sampling edge.
  always @(posedge clk) begin
    if (!NCE && !NWRT) begin
      mem[{RA, CA}] <= DIN;
      wr_addr_q.push_back(int'({RA, CA}));
    end else if (!NCE && NWRT) begin
      DO <= mem[{RA, CA}];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic          sl, sd, iv;
    logic [DW-1:0] id;
    logic          e_busy, e_rdy, e_ovld, e_nce, e_nwrt, e_done;
    logic [6:0]    e_addr;
  } vec_t;

  vec_t tv[6];

  task automatic do_load(input int mode);
    int k, cyc, errs, wbad;
    logic v;
    wr_addr_q.delete();
    start_load = 1'b1;
    @(negedge clk);
    chk("ld_start_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    start_load = 1'b0;
    k = 0; cyc = 0; errs = 0;
    while (k < 128 && cyc < 1000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      in_valid   = v;
      in_data    = v ? img[k] : DW'({$urandom, $urandom});
      start_dump = (cyc == 5);
      @(negedge clk);
      if (in_ready !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || out_valid !== 1'b0) errs++;
      if (NCE !== !v || NWRT !== !v || {RA, CA} !== k[6:0]) errs++;
      if (v && DIN !== img[k]) errs++;
      @(posedge clk); #1;
      cyc++;
      if (v) k++;
    end
    in_valid = 1'b0;
    start_dump = 1'b0;
    chk("ld_words", 64'(k), 64'(128));
    chk("ld_cycle_errs", 64'(errs), 64'(0));
    if (mode == 0) chk("ld_cycles", 64'(cyc), 64'(128));
    @(negedge clk);
    chk("ld_done", 64'(done), 64'(1));
    chk("ld_busy_end", 64'(busy), 64'(0));
    chk("ld_addr_end", 64'({RA, CA}), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("ld_done_pulse", 64'(done), 64'(0));
    chk("ld_stay_idle", 64'(busy), 64'(0));
    chk("ld_writes", 64'(wr_addr_q.size()), 64'(128));
    wbad = 0;
    for (int i = 0; i < 128; i++) begin
      if (i >= wr_addr_q.size() || wr_addr_q[i] != i || mem[i] !== img[i]) wbad++;
    end
    chk("ld_image", 64'(wbad), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_dump(input int mode, input int abort_at);
    int idx, cyc, errs, stall;
    logic rdy, ov;
    start_dump = 1'b1;
    @(negedge clk);
    chk("dp_start_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    start_dump = 1'b0;
    idx = 0; cyc = 0; errs = 0; stall = 0;
    while (idx < 128 && cyc < 3000) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = !(idx == 10 && stall < 5);
        default: rdy = ($urandom_range(0, 1) == 1);
      endcase
      out_ready = rdy;
      @(negedge clk);
      ov = out_valid;
      if (cyc == 0) begin
        chk("dp_rdreq_nce", 64'(NCE), 64'(0));
        chk("dp_rdreq_nwrt", 64'(NWRT), 64'(1));
      end
      if (cyc < 2) chk("dp_first_latency", 64'(out_valid), 64'(0));
      if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || NWRT !== 1'b1) errs++;
      if (ov) begin
        if (out_data !== img[idx] || {RA, CA} !== idx[6:0]) errs++;
        if (mode == 1 && idx == 10 && !rdy) begin
          chk("dp_stall_hold", 64'(out_data), 64'(30));
          stall++;
        end
        if (idx == abort_at) begin
          rstn = 1'b0;
          @(posedge clk); #1;
          rstn = 1'b1;
          out_ready = 1'b0;
          @(negedge clk);
          chk("dp_abort_busy", 64'(busy), 64'(0));
          chk("dp_abort_ovld", 64'(out_valid), 64'(0));
          chk("dp_abort_addr", 64'({RA, CA}), 64'(0));
          chk("dp_abort_done", 64'(done), 64'(0));
          chk("dp_abort_errs", 64'(errs), 64'(0));
          @(posedge clk); #1;
          return;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (ov && rdy) idx++;
    end
    out_ready = 1'b0;
    chk("dp_words", 64'(idx), 64'(128));
    chk("dp_cycle_errs", 64'(errs), 64'(0));
    if (mode == 0) chk("dp_cycles", 64'(cyc), 64'(384));
    if (mode == 1) chk("dp_stall_len", 64'(stall), 64'(5));
    @(negedge clk);
    chk("dp_done", 64'(done), 64'(1));
    chk("dp_busy_end", 64'(busy), 64'(0));
    chk("dp_ovld_end", 64'(out_valid), 64'(0));
    chk("dp_addr_end", 64'({RA, CA}), 64'(0));
    @(posedge clk); #1;
    @(negedge clk);
    chk("dp_done_pulse", 64'(done), 64'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int nwr;
    //        sl    sd    iv    id              busy  rdy   ovld  nce   nwrt  done  addr
    tv[0] = '{1'b0, 1'b0, 1'b1, 52'hBAD,        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0};
    tv[1] = '{1'b1, 1'b1, 1'b0, 52'h0,          1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 52'h0,          1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0};
    tv[3] = '{1'b0, 1'b1, 1'b1, 52'h5,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0};
    tv[4] = '{1'b1, 1'b1, 1'b0, 52'h0,          1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd1};
    tv[5] = '{1'b0, 1'b0, 1'b1, 52'h6,          1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7'd1};

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_nce", 64'(NCE), 64'(1));
    chk("rst_nwrt", 64'(NWRT), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ovld", 64'(out_valid), 64'(0));
    chk("rst_addr", 64'({RA, CA}), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;

    // Decode table: IDLE ignores in_valid, simultaneous starts pick LOAD, starts ignored while busy.
    for (int i = 0; i < 6; i++) begin
      start_load = tv[i].sl;
      start_dump = tv[i].sd;
      in_valid   = tv[i].iv;
      in_data    = tv[i].id;
      @(negedge clk);
      chk($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].e_busy));
      chk($sformatf("tv%0d_rdy", i), 64'(in_ready), 64'(tv[i].e_rdy));
      chk($sformatf("tv%0d_ovld", i), 64'(out_valid), 64'(tv[i].e_ovld));
      chk($sformatf("tv%0d_nce", i), 64'(NCE), 64'(tv[i].e_nce));
      chk($sformatf("tv%0d_nwrt", i), 64'(NWRT), 64'(tv[i].e_nwrt));
      chk($sformatf("tv%0d_done", i), 64'(done), 64'(tv[i].e_done));
      chk($sformatf("tv%0d_addr", i), 64'({RA, CA}), 64'(tv[i].e_addr));
      @(posedge clk); #1;
    end
    start_load = 1'b0;
    start_dump = 1'b0;

    // Reset while a load word is being presented: no write in that cycle.
    in_valid = 1'b1;
    in_data  = 52'hDEAD;
    rstn     = 1'b0;
    @(negedge clk);
    chk("rstld_nce", 64'(NCE), 64'(1));
    chk("rstld_nwrt", 64'(NWRT), 64'(1));
    nwr = wr_addr_q.size();
    @(posedge clk); #1;
    rstn = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rstld_busy", 64'(busy), 64'(0));
    chk("rstld_addr", 64'({RA, CA}), 64'(0));
    chk("rstld_nowrite", 64'(wr_addr_q.size()), 64'(nwr));
    @(posedge clk); #1;

    for (int i = 0; i < 128; i++) img[i] = {26'(i), 26'(i + 1)};
    do_load(0);

    for (int i = 0; i < 128; i++) img[i] = DW'(i * 3);
    do_load(1);
    do_dump(1, -1);
    do_dump(0, 40);
    do_dump(0, -1);

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 128; i++) img[i] = DW'({$urandom, $urandom});
      do_load(2);
      do_dump(2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
